// File: rtl/cache_pkg.sv
// Shared definitions for the L1 data cache: op codes, controller states,
// instruction field positions and counter width.
package cache_pkg;
    localparam int PROC_ID_HI = 31;
    localparam int PROC_ID_LO = 30;
    localparam int OP_HI      = 29;
    localparam int OP_LO      = 28;
    localparam int PID_HI     = 27;
    localparam int PID_LO     = 26;
    localparam int ADDR_W     = 26;
    localparam int PID_W      = PID_HI - PID_LO + 1;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_WRITE,
        S_RESP
    } state_e;
endpackage

// File: rtl/l1_tag_data_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational read
// port, one write port taking either a whole line or byte-enabled bytes.
module l1_tag_data_array #(
    parameter int LINES  = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [LINE_W-1:0]   rd_data,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic                line_we,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [LINE_W-1:0]   wr_line,
    input  logic                byte_we,
    input  logic [LINE_W/8-1:0] wr_be,
    input  logic [7:0]          wr_byte
);
    localparam int NBYTES = LINE_W / 8;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Only valid bits are cleared; tags and data are don't-care while invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end else if (byte_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_idx][8*b +: 8] <= wr_byte;
                end
            end
        end
    end
endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller
// with a req/ack port to the next level and saturating hit/miss counters.
module l1_cache_ctrl
    import cache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    plusclk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   instruction,
    input  logic                    request,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic                    cache_hit,
    output logic                    stall,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [3:0]              mem_be,
    input  logic [4*DATA_WIDTH-1:0] mem_rdata,
    input  logic                    mem_ack,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = PID_W + ADDR_W - 2 - IDX_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_e                  state;
    op_e                     op_q;
    logic [PID_W-1:0]        pid_q;
    logic [ADDR_W-1:0]       vaddr_q;
    logic [DATA_WIDTH-1:0]   din_q;

    logic [1:0]              offset;
    logic [IDX_W-1:0]        index;
    logic [TAG_W-1:0]        tag;
    logic [3:0]              be_onehot;
    logic                    rd_valid;
    logic [TAG_W-1:0]        rd_tag;
    logic [4*DATA_WIDTH-1:0] rd_data;
    logic                    lookup_hit;
    logic                    line_we;
    logic                    byte_we;
    op_e                     new_op;
    logic                    unused_proc_id;

    assign unused_proc_id = ^instruction[PROC_ID_HI:PROC_ID_LO];
    assign new_op         = op_e'(instruction[OP_HI:OP_LO]);

    // pid is part of the tag so different processes never alias on a line.
    assign offset     = vaddr_q[1:0];
    assign index      = vaddr_q[2 +: IDX_W];
    assign tag        = {pid_q, vaddr_q[ADDR_W-1:2+IDX_W]};
    assign be_onehot  = 4'b0001 << offset;
    assign lookup_hit = rd_valid && (rd_tag == tag);
    assign line_we    = (state == S_FILL) && mem_ack;
    assign byte_we    = (state == S_LOOKUP) && (op_q == OP_WRITE) && lookup_hit;

    l1_tag_data_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .LINE_W (4*DATA_WIDTH)
    ) u_array (
        .clk      (plusclk),
        .rst      (rst),
        .rd_idx   (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_idx   (index),
        .line_we  (line_we),
        .wr_tag   (tag),
        .wr_line  (mem_rdata),
        .byte_we  (byte_we),
        .wr_be    (be_onehot),
        .wr_byte  (din_q)
    );

    always_ff @(posedge plusclk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_q      <= OP_NOP;
            pid_q     <= '0;
            vaddr_q   <= '0;
            din_q     <= '0;
            cache_hit <= 1'b0;
            stall     <= 1'b0;
            dout      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            cache_hit <= 1'b0;
            case (state)
                // Capture stage: instruction and write data are latched once.
                S_IDLE: begin
                    stall <= 1'b0;
                    if (request) begin
                        op_q    <= new_op;
                        pid_q   <= instruction[PID_HI:PID_LO];
                        vaddr_q <= instruction[ADDR_W-1:0];
                        din_q   <= din;
                        if (new_op == OP_READ || new_op == OP_WRITE) begin
                            state <= S_LOOKUP;
                            stall <= 1'b1;
                        end else begin
                            state     <= S_RESP;
                            cache_hit <= 1'b1;
                        end
                    end
                end
                // Lookup stage: tag compare, counters, and memory request setup.
                S_LOOKUP: begin
                    mem_addr  <= {pid_q, vaddr_q[ADDR_W-1:2]};
                    mem_wdata <= din_q;
                    mem_be    <= be_onehot;
                    if (op_q == OP_READ) begin
                        if (lookup_hit) begin
                            dout      <= rd_data[{offset, 3'b000} +: DATA_WIDTH];
                            hit_cnt   <= sat_inc(hit_cnt);
                            state     <= S_RESP;
                            cache_hit <= 1'b1;
                            stall     <= 1'b0;
                        end else begin
                            miss_cnt <= sat_inc(miss_cnt);
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            state    <= S_FILL;
                        end
                    end else begin
                        if (lookup_hit) begin
                            hit_cnt <= sat_inc(hit_cnt);
                        end else begin
                            miss_cnt <= sat_inc(miss_cnt);
                        end
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                        state   <= S_WRITE;
                    end
                end
                // Memory stage: wait for the next level to acknowledge.
                S_FILL: begin
                    if (mem_ack) begin
                        dout      <= mem_rdata[{offset, 3'b000} +: DATA_WIDTH];
                        mem_req   <= 1'b0;
                        state     <= S_RESP;
                        cache_hit <= 1'b1;
                        stall     <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        state     <= S_RESP;
                        cache_hit <= 1'b1;
                        stall     <= 1'b0;
                    end
                end
                // Response stage: single-cycle completion pulse.
                S_RESP: begin
                    stall <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Randomized self-checking bench for l1_cache_ctrl against a line-level
// behavioural cache model with a cooperating memory responder.
module tb_l1_cache_ctrl;
    import cache_pkg::*;

    localparam int TB_LINES = 16;

    logic        plusclk;
    logic        rst;
    logic [31:0] instruction;
    logic        request;
    logic [7:0]  din;
    logic        cache_hit;
    logic        stall;
    logic [7:0]  dout;
    logic        mem_req;
    logic        mem_we;
    logic [25:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    l1_cache_ctrl #(.LINES(TB_LINES), .DATA_WIDTH(8), .ADDR_WIDTH(32)) dut (
        .plusclk     (plusclk),
        .rst         (rst),
        .instruction (instruction),
        .request     (request),
        .din         (din),
        .cache_hit   (cache_hit),
        .stall       (stall),
        .dout        (dout),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial plusclk = 1'b0;
    always #5 plusclk = ~plusclk;

    int          n_chk;
    int          n_fail;
    bit          in_resp;

    bit          m_valid [TB_LINES];
    int          m_tag   [TB_LINES];
    logic [31:0] m_line  [TB_LINES];
    int          m_hits;
    int          m_miss;
    logic [7:0]  m_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TB_LINES; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
        m_dout = 8'h00;
    endtask

    task automatic bump(inout int c);
        if (c < 65535) c++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge plusclk);
            @(negedge plusclk);
            chk("idle_hit", cache_hit, 0);
            in_resp = 1'b0;
        end
    endtask

    // One processor transaction; called at a negedge, returns at the RESP negedge.
    task automatic do_op(input logic [1:0] op, input logic [1:0] pid, input logic [25:0] addr,
                         input logic [7:0] wd, input int d, input logic [31:0] rdata, input bit noise);
        int a, idx, off, tagk, edges, req_cycles, exp_lat;
        bit hit, exp_req, req_seen, done;
        logic [3:0] exp_be;

        instruction = {2'($urandom_range(0, 3)), op, pid, addr};
        din         = wd;
        request     = 1'b1;
        if (in_resp) begin
            @(posedge plusclk);
            @(negedge plusclk);
            chk("hit_pulse", cache_hit, 0);
            chk("stall_idle", stall, 0);
        end
        @(posedge plusclk);
        @(negedge plusclk);
        request = 1'b0;

        a      = int'(addr);
        idx    = (a / 4) % TB_LINES;
        off    = a % 4;
        tagk   = int'(pid) * (1 << 26) + a / (4 * TB_LINES);
        exp_be = 4'(1 << off);
        hit    = m_valid[idx] && (m_tag[idx] == tagk);
        if (op == OP_READ) begin
            if (hit) begin
                exp_lat = 1;
                exp_req = 1'b0;
                bump(m_hits);
            end else begin
                exp_lat      = 2 + d;
                exp_req      = 1'b1;
                bump(m_miss);
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tagk;
                m_line[idx]  = rdata;
            end
            m_dout = m_line[idx][8*off +: 8];
        end else if (op == OP_WRITE) begin
            exp_lat = 2 + d;
            exp_req = 1'b1;
            if (hit) begin
                bump(m_hits);
                m_line[idx][8*off +: 8] = wd;
            end else begin
                bump(m_miss);
            end
        end else begin
            exp_lat = 0;
            exp_req = 1'b0;
        end

        edges = 0; req_cycles = 0; req_seen = 1'b0; done = 1'b0;
        while (!done && edges <= 40) begin
            mem_ack = 1'b0;
            if (cache_hit) begin
                done = 1'b1;
            end else begin
                chk("stall_busy", stall, 1);
                if (mem_req) begin
                    if (!req_seen) begin
                        req_seen = 1'b1;
                        chk("mem_we", mem_we, (op == OP_WRITE));
                        chk("mem_addr", mem_addr, {pid, addr[25:2]});
                        chk("mem_be", mem_be, exp_be);
                        if (op == OP_WRITE) chk("mem_wdata", mem_wdata, wd);
                    end
                    if (req_cycles == d) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rdata;
                    end else if (noise) begin
                        mem_rdata = $urandom;
                    end
                    req_cycles++;
                end else if (noise) begin
                    mem_ack   = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
                if (noise) begin
                    request     = 1'($urandom_range(0, 1));
                    instruction = $urandom;
                    din         = 8'($urandom);
                end
                @(posedge plusclk);
                @(negedge plusclk);
                edges++;
            end
        end
        request = 1'b0;
        mem_ack = 1'b0;
        in_resp = 1'b1;
        chk("done", done, 1);
        chk("latency", edges, exp_lat);
        chk("req_issued", req_seen, exp_req);
        chk("stall_resp", stall, 0);
        chk("mem_req_resp", mem_req, 0);
        chk("dout", dout, m_dout);
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_miss);
    endtask

    initial begin
        int n;
        n_chk = 0; n_fail = 0; in_resp = 1'b0;
        rst = 1'b0; request = 1'b0; instruction = '0; din = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge plusclk);
        chk("rst_hit", cache_hit, 0);
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_dout", dout, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_hcnt", hit_cnt, 0);
        chk("rst_mcnt", miss_cnt, 0);
        rst = 1'b1;
        @(negedge plusclk);

        do_op(OP_READ, 2'd0, 26'h10, 8'h00, 3, 32'hDDCCBBAA, 1'b0);
        chk("plan_fill_dout", dout, 8'hAA);
        chk("plan_fill_miss", miss_cnt, 1);
        do_op(OP_READ, 2'd0, 26'h13, 8'h00, 0, 32'h0, 1'b0);
        chk("plan_hit_dout", dout, 8'hDD);
        chk("plan_hit_cnt", hit_cnt, 1);
        do_op(OP_WRITE, 2'd0, 26'h11, 8'h55, 1, 32'h0, 1'b0);
        do_op(OP_READ, 2'd0, 26'h11, 8'h00, 0, 32'h0, 1'b0);
        chk("plan_wr_dout", dout, 8'h55);
        do_op(OP_READ, 2'd1, 26'h10, 8'h00, 2, 32'h44332211, 1'b0);
        chk("plan_pid_miss", miss_cnt, 2);
        do_op(OP_NOP, 2'd0, 26'h10, 8'h00, 0, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            do_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
                  26'($urandom_range(0, 255) | ($urandom_range(0, 1) << 12)),
                  8'($urandom), $urandom_range(0, 3), $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Reset while a fill is outstanding and being acknowledged.
        idle(1);
        instruction = {2'b00, OP_READ, 2'b00, 26'h10};
        request = 1'b1;
        @(posedge plusclk);
        @(negedge plusclk);
        request = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(posedge plusclk);
            @(negedge plusclk);
            n++;
        end
        chk("rstfill_req_up", mem_req, 1);
        #2;
        mem_ack = 1'b1; mem_rdata = 32'h99887766; rst = 1'b0;
        #1;
        chk("rstfill_req", mem_req, 0);
        chk("rstfill_stall", stall, 0);
        chk("rstfill_hcnt", hit_cnt, 0);
        chk("rstfill_mcnt", miss_cnt, 0);
        chk("rstfill_dout", dout, 0);
        @(negedge plusclk);
        mem_ack = 1'b0;
        rst = 1'b1;
        model_reset();
        in_resp = 1'b0;
        @(negedge plusclk);
        do_op(OP_READ, 2'd0, 26'h10, 8'h00, 1, 32'h0BADF00D, 1'b0);
        chk("rstfill_remiss", miss_cnt, 1);
        chk("rstfill_dout2", dout, 8'h0D);

        // Hit counter saturation from a preloaded near-full value.
        idle(1);
        force dut.hit_cnt = 16'hFFFE;
        @(posedge plusclk);
        @(negedge plusclk);
        release dut.hit_cnt;
        m_hits = 65534;
        do_op(OP_READ, 2'd0, 26'h11, 8'h00, 0, 32'h0, 1'b0);
        do_op(OP_READ, 2'd0, 26'h12, 8'h00, 0, 32'h0, 1'b0);
        do_op(OP_READ, 2'd0, 26'h13, 8'h00, 0, 32'h0, 1'b0);
        chk("sat_hold", hit_cnt, 16'hFFFF);
        idle(1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
